// File: rtl/muxn_arb.sv
// muxn_arb: N-channel input multiplexer with a single registered output stage.
// Each channel offers a WIDTH-bit word with a valid/ready handshake. One
// granted word per cycle moves into the output register, which drains through
// dout_valid/dout_ready. Grant selection is either manual (select input) or
// round-robin.
// Build option: define MUXN_ARB_RR_EN to compile in round-robin mode. Without
// it the mode input is ignored and the block always runs in manual mode.
module muxn_arb #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       din_valid,
    output logic [CHANNELS-1:0]       din_ready,
    input  logic [SEL_W-1:0]          select,
    input  logic                      mode,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
    input  logic                      dout_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic               load_ok;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [WIDTH-1:0]   grant_data;
    logic               xfer;

`ifdef MUXN_ARB_RR_EN
    logic [SEL_W-1:0]   rr_ptr;
`else
    logic               unused_mode;
    assign unused_mode = mode;
`endif

    // A new word may enter when the output is empty or is leaving this cycle.
    assign load_ok = (state == EMPTY) || dout_ready;

    // Pick the granted channel for this cycle from mode, select and pointer.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
`ifdef MUXN_ARB_RR_EN
        if (mode) begin
            // Walk from farthest to nearest so the channel closest after
            // rr_ptr overwrites any earlier candidate and wins.
            for (int k = CHANNELS; k >= 1; k--) begin
                if (din_valid[SEL_W'((int'(rr_ptr) + k) % CHANNELS)]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'((int'(rr_ptr) + k) % CHANNELS);
                    grant_data = din[((int'(rr_ptr) + k) % CHANNELS)*WIDTH +: WIDTH];
                end
            end
        end else
`endif
        begin
            // A select value beyond the last channel matches nothing.
            for (int i = 0; i < CHANNELS; i++) begin
                if ((select == SEL_W'(i)) && din_valid[SEL_W'(i)]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'(i);
                    grant_data = din[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Ready is one-hot on the granted channel, and silent during reset.
    assign din_ready = (rst_n && load_ok && grant_vld) ?
                       (CHANNELS'(1) << grant_idx) : '0;

    assign xfer = |(din_valid & din_ready);

    // Output register state machine and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
`ifdef MUXN_ARB_RR_EN
            rr_ptr     <= SEL_W'(CHANNELS - 1);
`endif
        end else if (xfer) begin
            state      <= FULL;
            dout       <= grant_data;
            dout_ch    <= grant_idx;
            dout_valid <= 1'b1;
`ifdef MUXN_ARB_RR_EN
            if (mode) begin
                rr_ptr <= grant_idx;
            end
`endif
        end else if ((state == FULL) && dout_ready) begin
            state      <= EMPTY;
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muxn_arb.sv
// Testbench for muxn_arb (WIDTH=8, CHANNELS=4). Stimulus pushes the expected
// output word for every input transfer into a queue; a monitor pops and
// compares whenever the DUT completes an output handshake.
module tb_muxn_arb;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] din;
    logic [CHANNELS-1:0]       din_valid;
    logic [CHANNELS-1:0]       din_ready;
    logic [SEL_W-1:0]          select;
    logic                      mode;
    logic [WIDTH-1:0]          dout;
    logic [SEL_W-1:0]          dout_ch;
    logic                      dout_valid;
    logic                      dout_ready;

    muxn_arb #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .select     (select),
        .mode       (mode),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] ch;
    } exp_t;

    exp_t sb[$];

    logic [WIDTH-1:0] ch_data [CHANNELS] = '{8'h3C, 8'h5A, 8'hA5, 8'hD3};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare every completed output handshake against the queue.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got data=%0h ch=%0d expected none", dout, dout_ch);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(dout), 32'(e.data));
                check("out_ch", 32'(dout_ch), 32'(e.ch));
            end
        end
    end

    // Apply one vector, check din_ready, queue the expected word, advance one edge.
    task automatic step(input string name, input logic md, input logic [SEL_W-1:0] sel,
                        input logic [CHANNELS-1:0] dv, input logic dr,
                        input logic [CHANNELS-1:0] exp_ready);
        mode       = md;
        select     = sel;
        din_valid  = dv;
        dout_ready = dr;
        #1;
        check(name, 32'(din_ready), 32'(exp_ready));
        for (int g = 0; g < CHANNELS; g++) begin
            if (exp_ready[g]) begin
                exp_t e;
                e.data = ch_data[g];
                e.ch   = SEL_W'(g);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < CHANNELS; i++) din[i*WIDTH +: WIDTH] = ch_data[i];
        rst_n      = 1'b0;
        din_valid  = 4'b1111;
        select     = '0;
        mode       = 1'b0;
        dout_ready = 1'b0;
        #1;
        check("ready_in_reset", 32'(din_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dout_ch", 32'(dout_ch), 32'h0);
        check("rst_dout_valid", 32'(dout_valid), 32'h0);
        rst_n = 1'b1;

        // manual grant of channel 2
        step("man_sel2", 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100);
        check("man_sel2_valid", 32'(dout_valid), 32'h1);
        check("man_sel2_dout", 32'(dout), 32'hA5);
        // selected channel not valid: no grant, word drains
        step("man_sel1_novalid", 1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000);
        check("man_sel1_empty", 32'(dout_valid), 32'h0);
        step("man_sel3", 1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000);
        // drain and load in the same cycle
        step("man_sel0", 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001);
        // backpressure for three cycles
        for (int c = 0; c < 3; c++) begin
            step("bp_ready", 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000);
            check("bp_dout", 32'(dout), 32'h3C);
            check("bp_valid", 32'(dout_valid), 32'h1);
        end
        step("bp_release", 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010);
        check("bp_release_dout", 32'(dout), 32'h5A);
        // held word unaffected by mode/select change
        step("hold_load", 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100);
        step("hold_modechg", 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000);
        check("hold_dout", 32'(dout), 32'hA5);
        check("hold_ch", 32'(dout_ch), 32'h2);
        // idle: drain, no grant
        step("idle_drain", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
        check("idle_empty", 32'(dout_valid), 32'h0);

        // reset while FULL discards the held word
        step("pre_rst_load", 1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000);
        step("pre_rst_hold", 1'b0, 2'd3, 4'b0000, 1'b0, 4'b0000);
        rst_n = 1'b0;
        din_valid = 4'b1111;
        #1;
        check("mid_rst_ready", 32'(din_ready), 32'h0);
        @(posedge clk);
        #1;
        sb.delete();
        check("mid_rst_valid", 32'(dout_valid), 32'h0);
        check("mid_rst_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;

`ifdef MUXN_ARB_RR_EN
        // round-robin sequence 0,1,2,3,0 after reset
        step("rr0", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
        step("rr1", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);
        step("rr2", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100);
        step("rr3", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000);
        step("rr4", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001);
        // manual transfer must not move the pointer (still at 0)
        step("rr_man", 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100);
        step("rr_after_man", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010);
        // skip invalid channels, wrap from 3 to 0
        step("rr_skip", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000);
        step("rr_wrap", 1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001);
`else
        // mode input ignored: manual select of channel 3
        step("norr_mode1", 1'b1, 2'd3, 4'b1001, 1'b1, 4'b1000);
        check("norr_ch", 32'(dout_ch), 32'h3);
`endif

        step("final_drain0", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
        step("final_drain1", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
